// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// special opcode / result-select constants and a small decode helper.
package instr_sequencer_pkg;

  // State encodings are visible on the state output, so they are fixed.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [3:0] HALT_OPCODE  = 4'b1111;
  localparam logic [1:0] MEM_LOAD_SEL = 2'b10;

  // An instruction needs the MEM phase when it stores or loads.
  function automatic logic needs_mem(input logic       mem_write,
                                     input logic [1:0] result_sel);
    return mem_write || (result_sel == MEM_LOAD_SEL);
  endfunction

endpackage

// File: rtl/instr_sequencer_retire_counter.sv
// 16-bit retired-instruction counter: synchronous reset, increment enable,
// natural wrap from 16'hFFFF to 16'h0000.
module retire_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  // Count retirements; reset wins over increment.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM
// with run / single-step control, HALT opcode and a retire counter.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        mem_ready,
  input  logic [3:0]  opCode,
  input  logic        dec_PC_Enable,
  input  logic        dec_RA_Enable,
  input  logic        dec_RegWrite_Enable,
  input  logic        dec_MemWrite_Enable,
  input  logic [1:0]  dec_Alu_Move_Mem,
  output logic        imem_req,
  output logic        IR_Load,
  output logic        dmem_req,
  output logic        PC_Enable,
  output logic        RA_Enable,
  output logic        RegWrite_Enable,
  output logic        MemWrite_Enable,
  output logic [2:0]  state,
  output logic        halted,
  output logic [15:0] instr_count
);

  state_t state_q, state_d;
  logic   step_flag_q, step_flag_d;

  // Ungated strobes as decoded from the current state.
  logic imem_req_c, ir_load_c, dmem_req_c;
  logic pc_en_c, ra_en_c, rw_en_c, mw_en_c, halted_c, retire_c;

  // State register and single-step flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      step_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_flag_q <= step_flag_d;
    end
  end

  // Next-state and per-state strobe decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    state_d     = state_q;
    step_flag_d = step_flag_q;
    imem_req_c  = 1'b0;
    ir_load_c   = 1'b0;
    dmem_req_c  = 1'b0;
    pc_en_c     = 1'b0;
    ra_en_c     = 1'b0;
    rw_en_c     = 1'b0;
    mw_en_c     = 1'b0;
    halted_c    = 1'b0;
    retire_c    = 1'b0;

    case (state_q)
      IDLE: begin
        // run has priority; a coincident step pulse is dropped.
        if (run) begin
          state_d = FETCH;
        end else if (step) begin
          step_flag_d = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        imem_req_c = 1'b1;
        if (mem_ready) begin
          ir_load_c = 1'b1;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        state_d = (opCode == HALT_OPCODE) ? HALT : EXEC;
      end
      EXEC: begin
        state_d = needs_mem(dec_MemWrite_Enable, dec_Alu_Move_Mem) ? MEM : WB;
      end
      MEM: begin
        dmem_req_c = 1'b1;
        // Write strobe only in the cycle the memory accepts the access.
        mw_en_c    = dec_MemWrite_Enable & mem_ready;
        if (mem_ready) begin
          state_d = WB;
        end
      end
      WB: begin
        pc_en_c  = dec_PC_Enable;
        ra_en_c  = dec_RA_Enable;
        rw_en_c  = dec_RegWrite_Enable;
        retire_c = 1'b1;
        if (step_flag_q) begin
          step_flag_d = 1'b0;
          state_d     = IDLE;
        end else if (run) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      HALT: begin
        halted_c = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset is synchronous, so the registered state is still live during the
  // reset cycle; masking here keeps every strobe quiet while reset is held
  // and abandons any in-flight fetch or memory access.
  assign imem_req        = imem_req_c & ~reset;
  assign IR_Load         = ir_load_c  & ~reset;
  assign dmem_req        = dmem_req_c & ~reset;
  assign PC_Enable       = pc_en_c    & ~reset;
  assign RA_Enable       = ra_en_c    & ~reset;
  assign RegWrite_Enable = rw_en_c    & ~reset;
  assign MemWrite_Enable = mw_en_c    & ~reset;
  assign halted          = halted_c   & ~reset;
  assign state           = state_q;

  retire_counter u_retire_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (retire_c),
    .count (instr_count)
  );

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus a
// randomized instruction stream checked against a per-instruction phase
// model derived from the sequencing rules.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        mem_ready = 1'b0;
  logic [3:0]  opCode = 4'd0;
  logic        dec_PC_Enable = 1'b0;
  logic        dec_RA_Enable = 1'b0;
  logic        dec_RegWrite_Enable = 1'b0;
  logic        dec_MemWrite_Enable = 1'b0;
  logic [1:0]  dec_Alu_Move_Mem = 2'b00;
  logic        imem_req, IR_Load, dmem_req;
  logic        PC_Enable, RA_Enable, RegWrite_Enable, MemWrite_Enable;
  logic [2:0]  state;
  logic        halted;
  logic [15:0] instr_count;

  logic        wrap_reset = 1'b1;
  logic        wrap_inc = 1'b0;
  logic [15:0] wrap_count;

  int          n_checks = 0;
  int          n_fails = 0;
  logic [15:0] model_count = 16'd0;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .run                 (run),
    .step                (step),
    .mem_ready           (mem_ready),
    .opCode              (opCode),
    .dec_PC_Enable       (dec_PC_Enable),
    .dec_RA_Enable       (dec_RA_Enable),
    .dec_RegWrite_Enable (dec_RegWrite_Enable),
    .dec_MemWrite_Enable (dec_MemWrite_Enable),
    .dec_Alu_Move_Mem    (dec_Alu_Move_Mem),
    .imem_req            (imem_req),
    .IR_Load             (IR_Load),
    .dmem_req            (dmem_req),
    .PC_Enable           (PC_Enable),
    .RA_Enable           (RA_Enable),
    .RegWrite_Enable     (RegWrite_Enable),
    .MemWrite_Enable     (MemWrite_Enable),
    .state               (state),
    .halted              (halted),
    .instr_count         (instr_count)
  );

  // Standalone counter instance: lets the 16-bit wrap be reached in 64k cycles.
  retire_counter u_wrap (
    .clk   (clk),
    .reset (wrap_reset),
    .inc   (wrap_inc),
    .count (wrap_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe vector: {imem_req, IR_Load, dmem_req, PC, RA, RegWrite, MemWrite, halted}
  function automatic logic [7:0] outs();
    return {imem_req, IR_Load, dmem_req, PC_Enable, RA_Enable,
            RegWrite_Enable, MemWrite_Enable, halted};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Settle, then compare state, strobes and retire count with expectations.
  task automatic cyc(input string tag, input int exp_state, input logic [7:0] exp_outs);
    #1;
    check({tag, " state"}, 32'(state), 32'(exp_state));
    check({tag, " strobes"}, 32'(outs()), 32'(exp_outs));
    check({tag, " count"}, 32'(instr_count), 32'(model_count));
  endtask

  task automatic noise_ctrl();
    run  = 1'($urandom);
    step = 1'($urandom);
  endtask

  task automatic set_dec(input logic [3:0] op, input logic pc, input logic ra,
                         input logic rw, input logic mw, input logic [1:0] sel);
    opCode = op;
    dec_PC_Enable = pc;
    dec_RA_Enable = ra;
    dec_RegWrite_Enable = rw;
    dec_MemWrite_Enable = mw;
    dec_Alu_Move_Mem = sel;
  endtask

  // Two reset cycles (strobes must stay low) then one released idle cycle.
  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      reset = 1'b1;
      run = 1'b1; step = 1'b1; mem_ready = 1'b1;
      set_dec(4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
      #1;
      check("in reset strobes", 32'(outs()), 32'h0);
    end
    model_count = 16'd0;
    tick();
    reset = 1'b0; run = 1'b0; step = 1'b0;
    cyc("after reset", 0, 8'h00);
  endtask

  task automatic idle_cycle(input logic r, input logic s);
    tick();
    run = r; step = s; mem_ready = 1'($urandom);
    cyc("idle", 0, 8'h00);
  endtask

  // One instruction starting in its first FETCH cycle. wf/wm are wait
  // cycles in FETCH/MEM; run_after is the run level presented in WB.
  task automatic exec_instr(input logic [3:0] op, input logic pc, input logic ra,
                            input logic rw, input logic mw, input logic [1:0] sel,
                            input int wf, input int wm, input logic run_after,
                            output int lat, output int pc_pulses, output int mw_pulses);
    logic is_mem;
    is_mem = mw || (sel == 2'b10);
    lat = 0; pc_pulses = 0; mw_pulses = 0;
    for (int i = 0; i <= wf; i++) begin
      tick();
      noise_ctrl();
      set_dec(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 2'($urandom));
      mem_ready = (i == wf);
      cyc("fetch", 1, {1'b1, (i == wf), 6'b0});
      lat++;
    end
    tick();
    noise_ctrl();
    set_dec(op, pc, ra, rw, mw, sel);
    mem_ready = 1'($urandom);
    cyc("decode", 2, 8'h00);
    lat++;
    tick();
    noise_ctrl();
    mem_ready = 1'($urandom);
    cyc("exec", 3, 8'h00);
    lat++;
    if (is_mem) begin
      for (int j = 0; j <= wm; j++) begin
        tick();
        noise_ctrl();
        mem_ready = (j == wm);
        cyc("mem", 4, {2'b00, 1'b1, 3'b000, mw & (j == wm), 1'b0});
        if (MemWrite_Enable) mw_pulses++;
        lat++;
      end
    end
    tick();
    run = run_after; step = 1'b0;
    mem_ready = 1'($urandom);
    cyc("wb", 5, {3'b000, pc, ra, rw, 2'b00});
    if (PC_Enable) pc_pulses++;
    lat++;
    model_count = model_count + 16'd1;
  endtask

  initial begin
    int lat, pcp, mwp;
    logic in_idle, single, is_mem, ra_v;
    logic [3:0] op;
    logic pc, ra, rw, mw;
    logic [1:0] sel;
    int wf, wm, start;

    // ---- reset state ----
    do_reset();

    // ---- run, non-memory instruction, mem_ready tied high ----
    idle_cycle(1'b1, 1'b0);
    exec_instr(4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 1'b0, lat, pcp, mwp);
    check("d1 latency", 32'(lat), 32'd4);
    check("d1 pc pulses", 32'(pcp), 32'd1);
    idle_cycle(1'b0, 1'b0);
    check("d1 instr_count", 32'(instr_count), 32'd1);

    // ---- memory instruction latency with mem_ready high ----
    idle_cycle(1'b1, 1'b0);
    exec_instr(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 0, 0, 1'b0, lat, pcp, mwp);
    check("load latency", 32'(lat), 32'd5);
    idle_cycle(1'b0, 1'b0);

    // ---- single step, store, 3 MEM wait cycles; flag beats run in WB ----
    do_reset();
    idle_cycle(1'b0, 1'b1);
    exec_instr(4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 0, 3, 1'b1, lat, pcp, mwp);
    check("d2 memwrite pulses", 32'(mwp), 32'd1);
    check("d2 latency", 32'(lat), 32'd8);
    idle_cycle(1'b0, 1'b0);
    check("d2 instr_count", 32'(instr_count), 32'd1);

    // ---- run and step together: continuous execution ----
    do_reset();
    idle_cycle(1'b1, 1'b1);
    exec_instr(4'b0011, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1, 0, 1'b1, lat, pcp, mwp);
    exec_instr(4'b0101, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 1'b0, lat, pcp, mwp);
    idle_cycle(1'b0, 1'b0);
    check("d3 instr_count", 32'(instr_count), 32'd2);

    // ---- HALT opcode ----
    do_reset();
    idle_cycle(1'b1, 1'b0);
    tick(); mem_ready = 1'b1; cyc("halt fetch", 1, 8'hC0);
    tick(); set_dec(4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10); cyc("halt decode", 2, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick(); noise_ctrl(); mem_ready = 1'($urandom);
      cyc("halted", 6, 8'h01);
    end
    do_reset();

    // ---- reset while waiting in MEM ----
    idle_cycle(1'b1, 1'b0);
    exec_instr(4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 1'b1, lat, pcp, mwp);
    tick(); mem_ready = 1'b1; cyc("rm fetch", 1, 8'hC0);
    tick(); set_dec(4'b0111, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00); cyc("rm decode", 2, 8'h00);
    tick(); cyc("rm exec", 3, 8'h00);
    tick(); mem_ready = 1'b0; cyc("rm mem wait", 4, 8'h20);
    tick(); reset = 1'b1; #1;
    check("rm in reset strobes", 32'(outs()), 32'h0);
    model_count = 16'd0;
    tick(); reset = 1'b0; run = 1'b0; mem_ready = 1'b1;
    cyc("rm after reset", 0, 8'h00);
    check("rm instr_count", 32'(instr_count), 32'd0);

    // ---- randomized instruction stream ----
    in_idle = 1'b1;
    single = 1'b0;
    for (int k = 0; k < 150; ) begin
      if (in_idle) begin
        start = int'($urandom_range(0, 2));
        if (start == 0) begin
          idle_cycle(1'b0, 1'b0);
        end else if (start == 1) begin
          idle_cycle(1'b1, 1'($urandom));
          in_idle = 1'b0; single = 1'b0;
        end else begin
          idle_cycle(1'b0, 1'b1);
          in_idle = 1'b0; single = 1'b1;
        end
      end else begin
        op = 4'($urandom_range(0, 14));
        pc = 1'($urandom); ra = 1'($urandom); rw = 1'($urandom); mw = 1'($urandom);
        sel = 2'($urandom);
        wf = int'($urandom_range(0, 3));
        wm = int'($urandom_range(0, 3));
        ra_v = 1'($urandom);
        is_mem = mw || (sel == 2'b10);
        exec_instr(op, pc, ra, rw, mw, sel, wf, wm, ra_v, lat, pcp, mwp);
        check("rnd latency", 32'(lat), 32'(wf + 4 + (is_mem ? wm + 1 : 0)));
        check("rnd memwrite pulses", 32'(mwp), 32'(is_mem && mw));
        check("rnd pc pulses", 32'(pcp), 32'(pc));
        in_idle = single || !ra_v;
        single = 1'b0;
        k++;
      end
    end
    if (!in_idle) begin
      tick(); mem_ready = 1'b1; run = 1'b0; cyc("rnd tail fetch", 1, 8'hC0);
    end

    // ---- retire counter wrap: 65536 increments return to zero ----
    tick(); wrap_reset = 1'b1; wrap_inc = 1'b1;
    tick(); wrap_reset = 1'b0; #1;
    check("wrap start", 32'(wrap_count), 32'h0);
    repeat (65535) @(negedge clk);
    #1;
    check("wrap ffff", 32'(wrap_count), 32'hFFFF);
    tick(); #1;
    check("wrap to zero", 32'(wrap_count), 32'h0);
    wrap_inc = 1'b0;
    tick(); #1;
    check("wrap hold", 32'(wrap_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 The block SHALL expose these ports (clock and reset first):
- clk  in  1  system clock, all state updates on its rising edge
- reset  in  1  synchronous active-high reset
- run  in  1  level: execute instructions continuously
- step  in  1  one-cycle pulse: execute exactly one instruction
- mem_ready  in  1  memory access completes this cycle
- opCode  in  4  instruction register opcode, valid from DECODE onward
- dec_PC_Enable, dec_RA_Enable, dec_RegWrite_Enable, dec_MemWrite_Enable  in  1 each  decoder outputs
- dec_Alu_Move_Mem  in  2  decoder result-source select; 2'b10 = memory load
- imem_req  out  1  instruction fetch request
- IR_Load  out  1  instruction register load strobe
- dmem_req  out  1  data memory request
- PC_Enable, RA_Enable, RegWrite_Enable, MemWrite_Enable  out  1 each  gated datapath enables
- state  out  3  current FSM state encoding
- halted  out  1  HALT state indicator
- instr_count  out  16  retired-instruction counter

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-004 In IDLE, run=1 SHALL move the FSM to FETCH next cycle.
REQ-005 In IDLE, step=1 with run=0 SHALL set the single-step flag and move the FSM to FETCH.
REQ-006 When run=1 and step=1 together in IDLE, run SHALL take priority and the step pulse SHALL be ignored.
REQ-007 In FETCH, imem_req SHALL be 1; the FSM SHALL remain in FETCH while mem_ready=0.
REQ-008 In FETCH with mem_ready=1, IR_Load SHALL pulse high in that same cycle and the FSM SHALL move to DECODE.
REQ-009 DECODE SHALL last exactly one cycle.
REQ-010 From DECODE, opCode=4'b1111 SHALL move the FSM to HALT; any other opCode SHALL move it to EXEC.
REQ-011 From EXEC, the FSM SHALL go to MEM when dec_MemWrite_Enable=1 or dec_Alu_Move_Mem=2'b10; otherwise it SHALL go to WB.
REQ-012 In MEM, dmem_req SHALL be 1 and MemWrite_Enable SHALL equal dec_MemWrite_Enable AND mem_ready.
REQ-013 The FSM SHALL remain in MEM until mem_ready=1, then move to WB.
REQ-014 In WB (exactly one cycle), PC_Enable, RA_Enable and RegWrite_Enable SHALL equal their dec_* inputs.
REQ-015 PC_Enable, RA_Enable and RegWrite_Enable SHALL be 0 in every state other than WB.
REQ-016 In WB, instr_count SHALL increment by 1, wrapping from 16'hFFFF to 16'h0000.
REQ-017 The transition out of WB SHALL be:
- single-step flag set: clear the flag and go to IDLE
- otherwise run=1: go to FETCH
- otherwise: go to IDLE
REQ-018 HALT SHALL hold halted=1 with all enables and requests at 0, and SHALL be left only by reset.
REQ-019 run and step changes outside IDLE/WB SHALL NOT alter the instruction in flight.
REQ-020 Instruction latency with mem_ready tied to 1 SHALL be:
- 4 cycles for a non-memory instruction (FETCH..WB)
- 5 cycles for a memory instruction
REQ-021 The state output SHALL use encodings IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.

Reset
REQ-022 Reset SHALL force, on the next clock edge: state=IDLE, single-step flag=0, instr_count=0.
REQ-023 While in reset and after it, all strobe, request and enable outputs and halted SHALL be 0 until a new fetch begins.
REQ-024 Reset asserted mid-fetch or mid-MEM SHALL abandon the access with no write strobe in the following cycle.

Structure
REQ-025 A shared package SHALL hold:
- the state enum with the REQ-021 encodings
- HALT_OPCODE = 4'b1111
- MEM_LOAD_SEL = 2'b10
REQ-026 The FSM SHALL be implemented in instr_sequencer itself.
REQ-027 The retire counter SHALL be a sub-module, retire_counter (16-bit, synchronous reset, increment enable, wrap).

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- run=1, mem_ready=1, opCode=4'b0001 (non-memory) -> WB reached 4 cycles after leaving IDLE; PC_Enable pulses once; instr_count=1.
- step pulse, opCode with dec_MemWrite_Enable=1, mem_ready low 3 cycles in MEM -> exactly one MemWrite_Enable cycle; FSM returns to IDLE; instr_count=1.
- run=1, opCode=4'b1111 -> halted=1 from cycle after DECODE; no WB enables; remains halted until reset.
- run=1 for 65536 instructions -> instr_count wraps to 16'h0000.
- reset asserted in MEM with mem_ready=0 -> state=0, no write strobe, instr_count=0.
- run=1 and step=1 simultaneously in IDLE -> continuous execution; FSM does not return to IDLE after the first WB.
